movavg_seq: RTL and testbench

Parametrised sequential moving-average engine: unsigned sum (or power-of-two mean) of the current sample and the previous TAPS-1 accepted samples, computed with a single adder over multiple cycles. Sits in the sample datapath of the smallseq design, between a valid/ready sample source and a valid/ready consumer. Adds configurable width and depth, optional averaging, backpressure and history clear.

---
 rtl/movavg_pkg.sv | 23 ++
 rtl/movavg_taps.sv | 34 +++
 rtl/movavg_seq.sv | 95 +++++++++
 tb/tb_movavg_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/movavg_pkg.sv
// Shared types and elaboration helpers for the sequential moving-average engine.
package movavg_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_OUT} state_t;

    function automatic int log2ceil(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Accumulator width: TAPS samples of WIDTH bits never overflow it.
    function automatic int acc_width(input int width, input int taps);
        return width + log2ceil(taps);
    endfunction

    // Index width for a history of 'depth' entries, at least one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? log2ceil(depth) : 1;
    endfunction

endpackage

// File: rtl/movavg_taps.sv
// History shift register: tap[0] newest, synchronous zeroing, one indexed read port.
module movavg_taps
    import movavg_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 3,
    parameter int IDXW  = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             i_zero,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_din,
    input  logic [IDXW-1:0]  i_idx,
    output logic [WIDTH-1:0] o_rd
);

    logic [DEPTH-1:0][WIDTH-1:0] r_tap;

    always_ff @(posedge clk) begin
        if (i_zero) begin
            r_tap <= '0;
        end else if (i_shift) begin
            r_tap[0] <= i_din;
            for (int k = 1; k < DEPTH; k++) r_tap[k] <= r_tap[k-1];
        end
    end

    always_comb begin
        o_rd = '0;
        for (int k = 0; k < DEPTH; k++)
            if (i_idx == IDXW'(k)) o_rd = r_tap[k];
    end

endmodule

// File: rtl/movavg_seq.sv
// Moving sum/mean over TAPS samples using one adder: IDLE captures, ACC walks the
// history one tap per cycle, OUT holds the result until the consumer takes it.
module movavg_seq
    import movavg_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int TAPS   = 4,
    parameter int DIVIDE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready
);

    localparam int LOG2T = log2ceil(TAPS);
    localparam int ACCW  = acc_width(WIDTH, TAPS);
    localparam int DEPTH = TAPS - 1;
    localparam int IDXW  = idx_width(DEPTH);

    if (WIDTH < 2 || TAPS < 2) begin : g_bad_size
        $error("movavg_seq: WIDTH and TAPS must both be >= 2");
    end
    if (DIVIDE == 1 && (TAPS & (TAPS - 1)) != 0) begin : g_bad_taps
        $error("movavg_seq: DIVIDE=1 needs TAPS to be a power of two");
    end

    state_t           r_state, w_next;
    logic             r_live;
    logic [WIDTH-1:0] r_smp;
    logic [ACCW-1:0]  r_acc;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] w_rd, w_res;
    logic             w_idle, w_take, w_shift, w_zero;

    // r_live keeps din_ready low for the whole reset and the edge that releases it.
    assign w_idle     = (r_state == ST_IDLE);
    assign din_ready  = w_idle && r_live && !clr;
    assign w_take     = din_ready && din_valid;
    assign dout_valid = (r_state == ST_OUT);
    assign w_shift    = dout_valid && dout_ready;
    assign w_zero     = !reset || (w_idle && clr);

    movavg_taps #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW)) u_taps (
        .clk     (clk),
        .i_zero  (w_zero),
        .i_shift (w_shift),
        .i_din   (r_smp),
        .i_idx   (r_idx),
        .o_rd    (w_rd)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_take) w_next = ST_ACC;
            ST_ACC:  if (r_idx == IDXW'(TAPS - 2)) w_next = ST_OUT;
            ST_OUT:  if (dout_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
            r_smp   <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (w_take) begin
                r_smp <= din;
                r_acc <= ACCW'(din);
                r_idx <= '0;
            end else if (r_state == ST_ACC) begin
                r_acc <= r_acc + ACCW'(w_rd);
                r_idx <= r_idx + IDXW'(1);
            end
        end
    end

    always_comb begin
        if (DIVIDE == 1) w_res = WIDTH'(r_acc >> LOG2T);
        else             w_res = r_acc[WIDTH-1:0];
        dout = dout_valid ? w_res : '0;
    end

endmodule

// File: tb/tb_movavg_seq.sv
// Scoreboard bench: a sum instance and a mean instance share stimulus; hand-computed
// expectations are queued at issue and popped by a monitor on each output transfer.
module tb_movavg_seq;

    logic       clk = 1'b0;
    logic       reset, clr, din_valid, dout_ready;
    logic [7:0] din;
    logic       rdy0, rdy1, dv0, dv1;
    logic [7:0] dout0, dout1;

    int total = 0;
    int bad   = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    movavg_seq #(.WIDTH(8), .TAPS(4), .DIVIDE(0)) dut0 (
        .clk(clk), .reset(reset), .clr(clr), .din(din), .din_valid(din_valid),
        .din_ready(rdy0), .dout(dout0), .dout_valid(dv0), .dout_ready(dout_ready)
    );

    movavg_seq #(.WIDTH(8), .TAPS(4), .DIVIDE(1)) dut1 (
        .clk(clk), .reset(reset), .clr(clr), .din(din), .din_valid(din_valid),
        .din_ready(rdy1), .dout(dout1), .dout_valid(dv1), .dout_ready(dout_ready)
    );

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Monitor: output transfers against the scoreboard, plus per-cycle invariants.
    always @(negedge clk) begin
        if (dv0 && dout_ready) begin
            total++;
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL sum_unexpected: got=%0d expected=none", dout0);
            end else begin
                logic [7:0] e;
                e = q0.pop_front();
                if (dout0 !== e) begin
                    bad++;
                    $display("FAIL sum_dout: got=%0d expected=%0d", dout0, e);
                end
            end
        end
        if (dv1 && dout_ready) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL mean_unexpected: got=%0d expected=none", dout1);
            end else begin
                logic [7:0] e;
                e = q1.pop_front();
                if (dout1 !== e) begin
                    bad++;
                    $display("FAIL mean_dout: got=%0d expected=%0d", dout1, e);
                end
            end
        end
        total++;
        if ((dv0 && rdy0) || (dv1 && rdy1) || (!dv0 && dout0 != 0) || (!dv1 && dout1 != 0)) begin
            bad++;
            $display("FAIL invariant: dv0=%0b rdy0=%0b dout0=%0d dv1=%0b rdy1=%0b dout1=%0d expected=exclusive_handshake_zero_idle",
                     dv0, rdy0, dout0, dv1, rdy1, dout1);
        end
    end

    // Issue one sample; with lat set, also check the 3-cycle latency and 4-cycle din_ready gap.
    task automatic send(input logic [7:0] v, input logic [7:0] e0, input logic [7:0] e1, input bit lat);
        int n;
        int first_dv;
        int low;
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk); #1;
        din = v;
        din_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rdy0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            chk("accept_timeout", n, 0);
        end else begin
            chk("ready_match", int'(rdy1), 1);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        if (lat) begin
            first_dv = 0;
            low = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (dv0 && first_dv == 0) first_dv = k;
                if (rdy0) break;
                low++;
            end
            chk("latency_edges", first_dv - 1, 3);
            chk("ready_low_cycles", low, 4);
        end
    endtask

    task automatic do_clr();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0; clr = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_dout_valid", int'(dv0 | dv1), 0);
            chk("reset_din_ready", int'(rdy0 | rdy1), 0);
            chk("reset_dout", int'(dout0 | dout1), 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        // sums 1,3,6,10,14; means 0,0,1,2,3
        send(8'd1, 8'd1,  8'd0, 1'b1);
        send(8'd2, 8'd3,  8'd0, 1'b1);
        send(8'd3, 8'd6,  8'd1, 1'b1);
        send(8'd4, 8'd10, 8'd2, 1'b1);
        send(8'd5, 8'd14, 8'd3, 1'b1);

        do_clr();
        send(8'd8, 8'd8,  8'd2, 1'b1);
        send(8'd8, 8'd16, 8'd4, 1'b1);
        send(8'd8, 8'd24, 8'd6, 1'b1);
        send(8'd8, 8'd32, 8'd8, 1'b1);
        do_clr();
        send(8'd255, 8'd255, 8'd63,  1'b1);
        send(8'd255, 8'd254, 8'd127, 1'b1);
        send(8'd255, 8'd253, 8'd191, 1'b1);
        send(8'd255, 8'd252, 8'd255, 1'b1);

        do_clr();
        send(8'd200, 8'd200, 8'd50,  1'b1);
        send(8'd200, 8'd144, 8'd100, 1'b1);

        // Backpressure: 10+0+200+200 = 410 -> 154 / 102, held for 5 cycles.
        @(posedge clk); #1;
        dout_ready = 1'b0;
        send(8'd10, 8'd154, 8'd102, 1'b0);
        n = 0;
        while (!dv0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached_out", int'(n < 20), 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("hold_valid", int'(dv0 & dv1), 1);
            chk("hold_ready", int'(rdy0 | rdy1), 0);
            chk("hold_sum", int'(dout0), 154);
            chk("hold_mean", int'(dout1), 102);
        end
        @(posedge clk); #1;
        dout_ready = 1'b1;
        @(posedge clk);
        // History must have shifted exactly once: 0+10+200+200.
        send(8'd0, 8'd154, 8'd102, 1'b1);

        // Reset during ACC of the third window aborts it and zeroes history.
        do_clr();
        send(8'd1, 8'd1, 8'd0, 1'b1);
        send(8'd2, 8'd3, 8'd0, 1'b1);
        @(posedge clk); #1;
        din = 8'd3;
        din_valid = 1'b1;
        @(negedge clk);
        chk("third_ready", int'(rdy0), 1);
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midreset_dout_valid", int'(dv0 | dv1), 0);
            chk("midreset_din_ready", int'(rdy0 | rdy1), 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_ready_first", int'(rdy0), 0);
        @(negedge clk);
        chk("post_reset_ready_second", int'(rdy0), 1);
        send(8'd7, 8'd7, 8'd1, 1'b1);

        // clr beats din_valid: sample refused, taps cleared.
        @(posedge clk); #1;
        clr = 1'b1;
        din = 8'd9;
        din_valid = 1'b1;
        @(negedge clk);
        chk("clr_blocks_ready", int'(rdy0 | rdy1), 0);
        @(posedge clk); #1;
        clr = 1'b0;
        din_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("clr_no_output_queue", q0.size(), 0);
        send(8'd9, 8'd9, 8'd2, 1'b1);

        repeat (4) @(negedge clk);
        chk("sum_queue_drained", q0.size(), 0);
        chk("mean_queue_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
